// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the VRAM arbiter.
package vram_arb_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 22;
  localparam int unsigned DATA_W         = 16;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitAcc,
    StWaitDone
  } state_e;

  // Which requester owns the current memory-controller command.
  typedef enum logic [1:0] {
    SelNone,
    SelVdp,
    SelRefresh,
    SelAux
  } sel_e;

endpackage

// File: rtl/vram_refresh_timer.sv
// Free-running refresh interval counter with a single pending flag and a
// sticky overdue flag raised when an interval elapses before the last refresh
// was granted.
module vram_refresh_timer #(
  parameter int unsigned Interval = 842
) (
  input  logic clk,
  input  logic reset_n,
  input  logic grant,
  output logic pending,
  output logic overdue
);

  localparam int unsigned CntW = (Interval > 1) ? $clog2(Interval) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Interval - 1);

  logic [CntW-1:0] cnt_q;
  logic            pending_q;
  logic            overdue_q;
  logic            wrap;

  assign wrap    = (cnt_q == CntMax);
  assign pending = pending_q;
  assign overdue = overdue_q;

  // Count 0..Interval-1; a wrap requests a refresh, a grant retires it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      overdue_q <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      if (wrap) begin
        pending_q <= 1'b1;
      end else if (grant) begin
        pending_q <= 1'b0;
      end
      if (wrap && pending_q && !grant) begin
        overdue_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates VDP slots, periodic refresh and an auxiliary requester onto a
// single memory-controller command port. VDP > refresh > aux.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned REFRESH_INTERVAL = 842,
  parameter int unsigned ADDR_W           = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vdp_slot,
  input  logic              vdp_we_n,
  input  logic [16:0]       vdp_addr,
  input  logic [7:0]        vdp_wdata,
  output logic [DATA_W-1:0] vdp_rdata,
  input  logic              aux_req,
  input  logic              aux_wr,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  input  logic [1:0]        aux_wmask,
  output logic              aux_ack,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              mc_read,
  output logic              mc_write,
  output logic              mc_refresh,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_din,
  output logic [1:0]        mc_wdm,
  input  logic [DATA_W-1:0] mc_dout,
  input  logic              mc_busy,
  output logic              vdp_overrun,
  output logic              refresh_overdue
);

  state_e state_q, state_d;
  sel_e   sel_q, sel_d, grant_sel;

  logic              slot_q, vdp_edge, vdp_pend_q, vdp_grant, overrun_q;
  logic [16:0]       pv_addr_q, src_addr;
  logic              pv_we_n_q, src_we_n;
  logic [7:0]        pv_wdata_q, src_wdata;
  logic              ref_pend, done, active;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_din_q, cmd_din_d, vdp_rdata_q, aux_rdata_q;
  logic [1:0]        cmd_wdm_q, cmd_wdm_d;
  logic              cmd_wr_q, cmd_wr_d, aux_ack_q, aux_rvalid_q;

  assign vdp_edge  = vdp_slot & ~slot_q;
  assign vdp_grant = (grant_sel == SelVdp);
  // A slot edge granted in the same cycle is served straight from the inputs.
  assign src_addr  = vdp_pend_q ? pv_addr_q  : vdp_addr;
  assign src_we_n  = vdp_pend_q ? pv_we_n_q  : vdp_we_n;
  assign src_wdata = vdp_pend_q ? pv_wdata_q : vdp_wdata;
  assign done      = (state_q == StWaitDone) && !mc_busy;
  assign active    = (state_q == StIssue) || (state_q == StWaitAcc);

  vram_refresh_timer #(
    .Interval(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .grant  (grant_sel == SelRefresh),
    .pending(ref_pend),
    .overdue(refresh_overdue)
  );

  // Next-state and grant decision; priority only evaluated in idle.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_sel = SelNone;
    unique case (state_q)
      StIdle: begin
        if (!mc_busy) begin
          if (vdp_pend_q || vdp_edge) begin
            grant_sel = SelVdp;
          end else if (ref_pend) begin
            grant_sel = SelRefresh;
          end else if (aux_req) begin
            grant_sel = SelAux;
          end
          if (grant_sel != SelNone) begin
            state_d = StIssue;
            sel_d   = grant_sel;
          end
        end
      end
      StIssue:    state_d = StWaitAcc;
      StWaitAcc:  if (mc_busy) state_d = StWaitDone;
      StWaitDone: if (!mc_busy) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Command fields latched at grant so later requests cannot disturb them.
  always_comb begin
    cmd_addr_d = cmd_addr_q;
    cmd_din_d  = cmd_din_q;
    cmd_wdm_d  = cmd_wdm_q;
    cmd_wr_d   = cmd_wr_q;
    unique case (grant_sel)
      SelVdp: begin
        cmd_addr_d = ADDR_W'(src_addr[15:0]);
        cmd_din_d  = {src_wdata, src_wdata};
        cmd_wdm_d  = {~src_addr[16], src_addr[16]};
        cmd_wr_d   = ~src_we_n;
      end
      SelAux: begin
        cmd_addr_d = aux_addr;
        cmd_din_d  = aux_wdata;
        cmd_wdm_d  = aux_wmask;
        cmd_wr_d   = aux_wr;
      end
      SelRefresh: begin
        cmd_addr_d = '0;
        cmd_din_d  = '0;
        cmd_wdm_d  = '0;
        cmd_wr_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // State, command and read-return registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      sel_q        <= SelNone;
      cmd_addr_q   <= '0;
      cmd_din_q    <= '0;
      cmd_wdm_q    <= '0;
      cmd_wr_q     <= 1'b0;
      aux_ack_q    <= 1'b0;
      aux_rvalid_q <= 1'b0;
      vdp_rdata_q  <= '0;
      aux_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_din_q    <= cmd_din_d;
      cmd_wdm_q    <= cmd_wdm_d;
      cmd_wr_q     <= cmd_wr_d;
      aux_ack_q    <= (grant_sel == SelAux);
      aux_rvalid_q <= done && !cmd_wr_q && (sel_q == SelAux);
      if (done && !cmd_wr_q && (sel_q == SelVdp)) vdp_rdata_q <= mc_dout;
      if (done && !cmd_wr_q && (sel_q == SelAux)) aux_rdata_q <= mc_dout;
    end
  end

  // VDP slot edge capture; an unserved request overwritten by a new edge is an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q     <= 1'b0;
      vdp_pend_q <= 1'b0;
      pv_addr_q  <= '0;
      pv_we_n_q  <= 1'b0;
      pv_wdata_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      slot_q <= vdp_slot;
      if (vdp_edge) begin
        pv_addr_q  <= vdp_addr;
        pv_we_n_q  <= vdp_we_n;
        pv_wdata_q <= vdp_wdata;
        vdp_pend_q <= vdp_pend_q | ~vdp_grant;
        if (vdp_pend_q && !vdp_grant) overrun_q <= 1'b1;
      end else if (vdp_grant) begin
        vdp_pend_q <= 1'b0;
      end
    end
  end

  assign mc_refresh  = active && (sel_q == SelRefresh);
  assign mc_read     = active && ((sel_q == SelVdp) || (sel_q == SelAux)) && !cmd_wr_q;
  assign mc_write    = active && ((sel_q == SelVdp) || (sel_q == SelAux)) && cmd_wr_q;
  assign mc_addr     = cmd_addr_q;
  assign mc_din      = cmd_din_q;
  assign mc_wdm      = cmd_wdm_q;
  assign aux_ack     = aux_ack_q;
  assign aux_rvalid  = aux_rvalid_q;
  assign vdp_rdata   = vdp_rdata_q;
  assign aux_rdata   = aux_rdata_q;
  assign vdp_overrun = overrun_q;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter REFRESH_INTERVAL, default 842, meaning clk cycles between mandatory refreshes (7.8 us at 108 MHz).
REQ-002 The block SHALL have parameter ADDR_W, default 22, meaning the memory-controller word address width.
REQ-003 Port clk  in  1  single clock for the whole block (SDRAM-side domain).
REQ-004 Port reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port vdp_slot  in  1  VDP access window (DLClk&DHClk), already synchronous to clk.
REQ-006 Port vdp_we_n  in  1  low = VDP write.
REQ-007 Port vdp_addr  in  17  VDP byte address; bit 16 selects the byte lane.
REQ-008 Port vdp_wdata  in  8  VDP write byte.
REQ-009 Port vdp_rdata  out  16  last VDP read word.
REQ-010 Port aux_req / aux_wr  in  1 / 1  auxiliary requester request level and write flag.
REQ-011 Port aux_addr / aux_wdata / aux_wmask  in  ADDR_W / 16 / 2  auxiliary address, data, and byte mask (mask bit 1 = lane disabled).
REQ-012 Port aux_ack  out  1  one-cycle pulse on aux command acceptance.
REQ-013 Port aux_rvalid / aux_rdata  out  1 / 16  one-cycle pulse with read data.
REQ-014 Port mc_read / mc_write / mc_refresh  out  1 each  command strobes to memory_controller.
REQ-015 Port mc_addr / mc_din / mc_wdm  out  ADDR_W / 16 / 2  command address, data, and mask.
REQ-016 Port mc_dout / mc_busy  in  16 / 1  controller read data and busy flag.
REQ-017 Port vdp_overrun / refresh_overdue  out  1 / 1  sticky error flags.

Function
REQ-018 A rising edge of vdp_slot SHALL latch a VDP request (vdp_addr, vdp_we_n, vdp_wdata) into a pending register on that cycle.
REQ-019 A VDP write SHALL drive mc_addr={6'b0,vdp_addr[15:0]}, mc_din={vdp_wdata,vdp_wdata}, mc_wdm={~vdp_addr[16],vdp_addr[16]}.
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT_ACC, and WAIT_DONE.
- IDLE -> ISSUE when any request is pending.
- ISSUE asserts exactly one strobe -> WAIT_ACC.
- WAIT_ACC holds the strobe until mc_busy=1, then -> WAIT_DONE with the strobe low.
- WAIT_DONE -> IDLE on mc_busy=0.
REQ-021 Priority evaluated in IDLE SHALL be: VDP pending > refresh pending > aux_req.
REQ-022 aux_ack SHALL pulse on the IDLE->ISSUE transition for an aux grant; aux inputs are sampled on that cycle.
REQ-023 Read completion (WAIT_DONE->IDLE) SHALL capture mc_dout into vdp_rdata (VDP) or aux_rdata with aux_rvalid=1 for one cycle (aux). vdp_rdata holds until the next VDP read completes.
REQ-024 Minimum latency SHALL be 1 cycle from pending request to strobe and 1 cycle from busy-fall to data valid.
REQ-025 The refresh counter SHALL count 0..REFRESH_INTERVAL-1, wrap, and set refresh pending on wrap. A refresh grant clears pending.
REQ-026 A wrap while refresh is still pending SHALL set refresh_overdue (sticky); pending stays single.
REQ-027 A new vdp_slot rising edge while a VDP request is still pending (not yet in ISSUE) SHALL overwrite the pending request and set vdp_overrun (sticky).
REQ-028 Simultaneous VDP edge and aux_req in IDLE: VDP SHALL be granted; aux_ack SHALL stay low.
REQ-029 mc_busy already high in IDLE SHALL block leaving IDLE.

Reset
REQ-030 Asserting reset_n=0 SHALL immediately force state IDLE, all strobes 0, aux_ack=0, aux_rvalid=0, vdp_rdata=0, aux_rdata=0, both flags 0, pending cleared, and the refresh counter to 0, including mid-transaction.
REQ-031 After release, the first refresh SHALL become pending after REFRESH_INTERVAL cycles.

Structure
REQ-032 Package vram_arb_pkg SHALL hold the state enum, the requester-select enum, and the ADDR_W/DATA_W defaults.
REQ-033 The refresh counter and flag SHALL be a sub-module vram_refresh_timer; the remainder is flat.

Verification
REQ-034 VDP write to addr 17'h1_0123 with data 8'hA5 -> mc_write, mc_addr=22'h000123, mc_din=16'hA5A5, mc_wdm=2'b01.
REQ-035 VDP read to 17'h00040, mc_dout=16'hBEEF at busy-fall -> vdp_rdata=16'hBEEF the next cycle, held thereafter.
REQ-036 aux_req with VDP edge in the same cycle -> VDP served first; aux_ack pulses after the VDP mc_busy falls.
REQ-037 REFRESH_INTERVAL=8 with aux_req held continuously -> mc_refresh issued within one transaction of the wrap; refresh_overdue stays 0.
REQ-038 mc_busy held high for 20 cycles with REFRESH_INTERVAL=8 -> refresh_overdue=1; a second VDP edge -> vdp_overrun=1.
REQ-039 reset_n pulsed low during WAIT_ACC -> strobes drop the same cycle; all outputs reach reset values.
